// File: rtl/addsub_seq_pkg.sv
// Shared opcodes, FSM encoding and sizing helper for the sequential adder/subtractor.
package addsub_seq_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Index width that stays at least one bit wide for single-slice builds.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/addsub_seq_if.sv
// Operand/result handshake bundle between a producer, the adder/subtractor and a consumer.
interface addsub_seq_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport slave (
      input  in_valid, x, y, op, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );

   modport master (
      output in_valid, x, y, op, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/addsub_seq_chunk.sv
// Combinational CHUNK-bit ripple-carry slice; also exposes the carry into its top bit.
module addsub_chunk #(
   parameter int unsigned CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             c_top
);
   logic [CHUNK:0] w_c;

   always_comb begin
      w_c    = '0;
      s      = '0;
      w_c[0] = cin;
      for (int i = 0; i < int'(CHUNK); i++) begin
         s[i]     = a[i] ^ b[i] ^ w_c[i];
         w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
      end
   end

   assign cout  = w_c[CHUNK];
   assign c_top = w_c[CHUNK-1];
endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement adder/subtractor: one shared CHUNK-bit slice walks the
// operands LSB-first, carrying between slices in a register.
module addsub_seq
   import addsub_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic              clk,
   input  logic              rst,
   addsub_seq_if.slave       bus
);
   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned IDXW   = idx_width(NCHUNK);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDXW-1:0]  r_idx;
   logic             r_carry;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;

   logic [CHUNK-1:0] w_a;
   logic [CHUNK-1:0] w_b;
   logic [CHUNK-1:0] w_s;
   logic             w_cout;
   logic             w_ctop;
   logic             w_accept;
   logic             w_run;
   logic             w_last;

   assign w_accept = (r_state == ST_IDLE) && bus.in_valid;
   assign w_run    = (r_state == ST_RUN);
   assign w_last   = w_run && (r_idx == LAST_IDX);
   assign w_a      = r_x[r_idx*CHUNK +: CHUNK];
   assign w_b      = r_y[r_idx*CHUNK +: CHUNK];

   addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (w_a),
      .b     (w_b),
      .cin   (r_carry),
      .s     (w_s),
      .cout  (w_cout),
      .c_top (w_ctop)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (bus.in_valid)  w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last)        w_state_nxt = ST_DONE;
         ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
         default:                    w_state_nxt = ST_IDLE;
      endcase
   end

   // Subtraction is folded in at capture time: Y is inverted and the carry seeded with 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_x     <= bus.x;
         r_y     <= bus.y ^ {WIDTH{bus.op}};
         r_carry <= bus.op;
         r_idx   <= '0;
      end else if (w_run) begin
         r_sum[r_idx*CHUNK +: CHUNK] <= w_s;
         r_carry <= w_cout;
         r_idx   <= r_idx + IDXW'(1);
         if (w_last) begin
            r_cout <= w_cout;
            r_ovf  <= w_ctop ^ w_cout;
         end
      end
   end

   assign bus.in_ready  = (r_state == ST_IDLE) && !rst;
   assign bus.out_valid = (r_state == ST_DONE);
   assign bus.sum       = r_sum;
   assign bus.cout      = r_cout;
   assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq: table vectors, random vectors against a scoreboard,
// backpressure, mid-run reset and alternate slice widths.
module tb_addsub_seq;
   localparam int unsigned W = 16;

   typedef struct {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         op;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         tb_in_valid;
   logic         tb_out_ready;
   logic [W-1:0] tb_x;
   logic [W-1:0] tb_y;
   logic         tb_op;
   int           sel;

   logic         m_in_ready;
   logic         m_out_valid;
   logic [W-1:0] m_sum;
   logic         m_cout;
   logic         m_ovf;

   int   checks = 0;
   int   errors = 0;
   res_t exp_q[$];
   int   lat_of[3] = '{4, 1, 16};
   vec_t vecs[7];

   always #5 clk = ~clk;

   addsub_seq_if #(.WIDTH(W)) if_a ();
   addsub_seq_if #(.WIDTH(W)) if_b ();
   addsub_seq_if #(.WIDTH(W)) if_c ();

   assign if_a.in_valid  = tb_in_valid  && (sel == 0);
   assign if_b.in_valid  = tb_in_valid  && (sel == 1);
   assign if_c.in_valid  = tb_in_valid  && (sel == 2);
   assign if_a.out_ready = tb_out_ready && (sel == 0);
   assign if_b.out_ready = tb_out_ready && (sel == 1);
   assign if_c.out_ready = tb_out_ready && (sel == 2);
   assign if_a.x = tb_x;  assign if_a.y = tb_y;  assign if_a.op = tb_op;
   assign if_b.x = tb_x;  assign if_b.y = tb_y;  assign if_b.op = tb_op;
   assign if_c.x = tb_x;  assign if_c.y = tb_y;  assign if_c.op = tb_op;

   addsub_seq #(.WIDTH(W), .CHUNK(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if_a));
   addsub_seq #(.WIDTH(W), .CHUNK(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if_b));
   addsub_seq #(.WIDTH(W), .CHUNK(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if_c));

   always_comb begin
      m_in_ready  = if_a.in_ready;
      m_out_valid = if_a.out_valid;
      m_sum       = if_a.sum;
      m_cout      = if_a.cout;
      m_ovf       = if_a.ovf;
      case (sel)
         1: begin
            m_in_ready = if_b.in_ready; m_out_valid = if_b.out_valid;
            m_sum = if_b.sum; m_cout = if_b.cout; m_ovf = if_b.ovf;
         end
         2: begin
            m_in_ready = if_c.in_ready; m_out_valid = if_c.out_valid;
            m_sum = if_c.sum; m_cout = if_c.cout; m_ovf = if_c.ovf;
         end
         default: ;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference from full-width arithmetic; overflow from operand/result sign rule.
   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic op);
      logic [W-1:0] yy;
      logic [W:0]   t;
      res_t         r;
      yy     = y ^ {W{op}};
      t      = {1'b0, x} + {1'b0, yy} + (W+1)'(op);
      r.sum  = t[W-1:0];
      r.cout = t[W];
      r.ovf  = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
      return r;
   endfunction

   function automatic vec_t mk(input logic [W-1:0] x, input logic [W-1:0] y, input logic op,
                               input logic [W-1:0] s, input logic c, input logic v);
      vec_t r;
      r.x = x; r.y = y; r.op = op; r.sum = s; r.cout = c; r.ovf = v;
      return r;
   endfunction

   // Present one operand pair; returns at the negedge after the accept edge.
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic op,
                        input res_t exp);
      int n;
      n = 0;
      @(negedge clk);
      while (!m_in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
      end
      tb_x = x; tb_y = y; tb_op = op; tb_in_valid = 1'b1;
      @(posedge clk);
      exp_q.push_back(exp);
      @(negedge clk);
      tb_in_valid = 1'b0;
      tb_x = W'($urandom); tb_y = W'($urandom); tb_op = 1'($urandom);
   endtask

   // Wait for the result, check latency and value, optionally stall, then complete handshake.
   task automatic collect(input int lat_want, input int hold);
      int   lat;
      res_t e;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!m_out_valid && lat < 100);
      chk("latency", 32'(lat), 32'(lat_want));
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
         e = '0;
      end else begin
         e = exp_q.pop_front();
      end
      chk("sum",  32'(m_sum),  32'(e.sum));
      chk("cout", 32'(m_cout), 32'(e.cout));
      chk("ovf",  32'(m_ovf),  32'(e.ovf));
      for (int i = 0; i < hold; i++) begin
         tb_in_valid = 1'b1; tb_x = 16'hAAAA; tb_y = 16'h5555; tb_op = 1'b0;
         @(posedge clk);
         @(negedge clk);
         chk("hold_valid", 32'(m_out_valid), 32'd1);
         chk("hold_ready", 32'(m_in_ready),  32'd0);
         chk("hold_sum",   32'(m_sum),       32'(e.sum));
         chk("hold_flags", {30'd0, m_cout, m_ovf}, {30'd0, e.cout, e.ovf});
      end
      tb_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tb_out_ready = 1'b0;
      chk("post_valid", 32'(m_out_valid), 32'd0);
      chk("post_ready", 32'(m_in_ready),  32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = mk(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
      vecs[1] = mk(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      vecs[2] = mk(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      vecs[3] = mk(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      vecs[4] = mk(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      vecs[5] = mk(16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b0);
      vecs[6] = mk(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

      sel = 0; rst = 1'b1;
      tb_in_valid = 1'b0; tb_out_ready = 1'b0; tb_x = '0; tb_y = '0; tb_op = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready",  32'(m_in_ready),  32'd0);
      chk("rst_out_valid", 32'(m_out_valid), 32'd0);
      chk("rst_sum",       32'(m_sum),       32'd0);
      chk("rst_flags",     {30'd0, m_cout, m_ovf}, 32'd0);
      rst = 1'b0;
      #1 chk("rel_in_ready", 32'(m_in_ready), 32'd1);

      foreach (vecs[i]) begin
         issue(vecs[i].x, vecs[i].y, vecs[i].op, '{vecs[i].sum, vecs[i].cout, vecs[i].ovf});
         collect(lat_of[0], 0);
      end

      for (int i = 0; i < 6; i++) begin
         logic [W-1:0] rx, ry;
         logic         rop;
         rx = W'($urandom); ry = W'($urandom); rop = 1'($urandom);
         issue(rx, ry, rop, model(rx, ry, rop));
         collect(lat_of[0], 0);
      end

      // Backpressure: pending in_valid with new operands must wait for the handshake.
      issue(16'h1234, 16'h0FFF, 1'b0, '{16'h2233, 1'b0, 1'b0});
      collect(lat_of[0], 3);
      @(posedge clk);
      exp_q.push_back('{16'hFFFF, 1'b0, 1'b0});
      @(negedge clk);
      tb_in_valid = 1'b0;
      chk("bp_accepted", 32'(m_in_ready), 32'd0);
      collect(lat_of[0], 0);

      // Reset two slices into a run.
      issue(16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0});
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready",  32'(m_in_ready),  32'd0);
      chk("mid_rst_out_valid", 32'(m_out_valid), 32'd0);
      chk("mid_rst_sum",       32'(m_sum),       32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rel_in_ready",  32'(m_in_ready),  32'd1);
      chk("mid_rel_out_valid", 32'(m_out_valid), 32'd0);
      exp_q = {};
      issue(16'h0003, 16'h0004, 1'b0, '{16'h0007, 1'b0, 1'b0});
      collect(lat_of[0], 0);

      // Alternate slice widths.
      for (int s = 1; s <= 2; s++) begin
         sel = s;
         issue(16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0});
         collect(lat_of[s], 0);
         issue(16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1});
         collect(lat_of[s], 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
